// File: rtl/btn_debounce_multi_pkg.sv
// Shared types, default parameter values and the width helper for the
// multi-channel button debouncer.
package btn_debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_REL  = 2'd0,
    ST_PRS  = 2'd1,
    ST_LONG = 2'd2
  } ch_state_e;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_TICK_HZ      = 1000;
  localparam int unsigned DEF_DB_TICKS     = 10;
  localparam int unsigned DEF_LONG_TICKS   = 1000;
  localparam int unsigned DEF_REPEAT_TICKS = 100;
  localparam bit          DEF_ACTIVE_LOW   = 1'b0;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_ch_fsm.sv
// One input channel: 2-FF synchroniser, tick-sampled debounce, and the
// press/long/release pulse FSM. BTN_REPEAT_EN adds typematic repeat in LONG.
module btn_ch_fsm
  import btn_debounce_multi_pkg::*;
#(
  parameter int unsigned DB_TICKS     = DEF_DB_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit          ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned       DB_W     = clog2(DB_TICKS);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_TICKS - 1);
  localparam int unsigned       HOLD_W   = clog2(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
  localparam int unsigned       REP_W    = clog2(REPEAT_TICKS);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0]  r_rep_cnt;
`endif

  logic [1:0]        r_sync;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  ch_state_e         r_state;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_long;

  logic              w_s;
  logic              w_diff;
  logic              w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  assign w_s      = r_sync[1] ^ ACTIVE_LOW;
  assign w_diff   = (w_s != r_level);
  // New level accepted on this tick: the sample has differed for DB_TICKS ticks.
  assign w_accept = i_tick && w_diff && (r_db_cnt == DB_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_state    <= ST_REL;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_rep_cnt  <= '0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      if (i_tick) begin
        if (!w_diff) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_MAX) begin
          r_db_cnt <= '0;
          r_level  <= w_s;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end

        case (r_state)
          ST_REL: begin
            if (w_accept && w_s) begin
              r_state    <= ST_PRS;
              r_press    <= 1'b1;
              r_hold_cnt <= '0;
            end
          end
          ST_PRS: begin
            if (w_accept) begin
              r_state   <= ST_REL;
              r_release <= 1'b1;
            end else if (r_hold_cnt == HOLD_MAX) begin
              r_state   <= ST_LONG;
              r_long    <= 1'b1;
`ifdef BTN_REPEAT_EN
              r_rep_cnt <= '0;
`endif
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          ST_LONG: begin
            if (w_accept) begin
              r_state   <= ST_REL;
              r_release <= 1'b1;
            end
`ifdef BTN_REPEAT_EN
            else if (r_rep_cnt == REP_MAX) begin
              r_press   <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
`endif
          end
          default: r_state <= ST_REL;
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/btn_debounce_multi.sv
// N_CH-channel button debouncer: shared sample-tick prescaler plus one
// btn_ch_fsm per channel. Define BTN_REPEAT_EN for auto-repeat while held.
module btn_debounce_multi
  import btn_debounce_multi_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned DB_TICKS     = DEF_DB_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit          ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic            o_tick
);

  localparam int unsigned      DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned      DIV_W   = clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;

  // Tick is registered off the wrap, so it is one clk wide every DIV clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt == DIV_MAX) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_tick    <= 1'b0;
    end
  end

  assign o_tick = r_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_ch_fsm #(
      .DB_TICKS     (DB_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (r_tick),
      .i_btn     (i_btn[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_long    (o_long[g])
    );
  end

endmodule
